writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001: Parameter DEPTH, default 4, number of queued write-back entries; SHALL be a power of two in the range 2..16.
REQ-002: Clk  input  1  clock; all state SHALL update on the positive edge.
REQ-003: Reset  input  1  asynchronous, active-high reset.
REQ-004: InValid  input  1  producer offers a result this cycle.
REQ-005: InReady  output  1  queue can accept; a transfer occurs on a posedge where InValid && InReady.
REQ-006: InRegister  input  5  destination register address of the offered result.
REQ-007: InData  input  32  result value.
REQ-008: Stall  input  1  register file write port unavailable; when high, no drain occurs.
REQ-009: WriteRegister  output  5  write address driven to the register file.
REQ-010: WriteData  output  32  write data driven to the register file.
REQ-011: RegWrite  output  1  write enable driven to the register file.
REQ-012: Count  output  clog2(DEPTH)+1  number of queued entries.
REQ-013: Empty / Full  output  1 each  Count==0 / Count==DEPTH.

Function
REQ-014: The queue SHALL be strict FIFO; entries drain in acceptance order.
REQ-015: InReady SHALL equal !Full, derived from registered state only; it SHALL NOT depend on InValid or Stall.
REQ-016: A transfer with InRegister==0 SHALL be accepted (handshake completes) and discarded; Count SHALL NOT change and no register file write SHALL result.
REQ-017: RegWrite SHALL equal !Empty && !Stall, combinationally.
REQ-018: WriteRegister/WriteData SHALL present the head entry when !Empty and 0 when Empty.
REQ-019: On a posedge with RegWrite high, the head entry SHALL pop; the register file captures it on the same edge.
REQ-020: Latency: a result accepted at edge N SHALL appear on WriteRegister/WriteData in the cycle after edge N when the queue was empty, with RegWrite high unless Stall is high.
REQ-021: Simultaneous push and pop SHALL leave Count unchanged and preserve order.
REQ-022: When Full, pushes SHALL be refused; a pop in the same cycle SHALL NOT enable a same-cycle push.
REQ-023: Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-024: Stall held indefinitely SHALL hold all queued entries and outputs stable.

Reset
REQ-025: Reset high SHALL immediately clear pointers and Count to 0, force Empty=1, Full=0, RegWrite=0, and WriteRegister/WriteData=0.
REQ-026: InReady SHALL be 1 in the first cycle after Reset deasserts.
REQ-027: Reset mid-operation SHALL discard all queued entries; storage contents need not be cleared.

Configuration
REQ-028: Macro WRITEBACK_QUEUE_LOOKUP_EN SHALL add the ports LookupRegister (input, 5), LookupHit (output, 1) and LookupData (output, 32).
REQ-029: With the macro defined, LookupHit SHALL be high when any queued entry matches a nonzero LookupRegister; LookupData SHALL return the newest matching entry's data, else 0; both are combinational.
REQ-030: With the macro defined, an entry being accepted in the current cycle SHALL NOT be visible to the lookup until after the edge.
REQ-031: Without the macro, the lookup ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032: Reset, then push (5, 0xDEADBEEF) with Stall=0 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; Empty=1 after the following edge.
REQ-033: Stall=1, push 4 entries (r1..r4, data 0x11..0x44) -> Full=1, InReady=0, a 5th push is refused; release Stall -> four writes r1..r4 in order on consecutive cycles.
REQ-034: Push (0, 0x12345678) -> handshake completes, Count stays 0, RegWrite stays 0.
REQ-035: Continuous push and pop for 20 cycles with DEPTH=4 -> pointers wrap, Count constant, all 20 writes in order.
REQ-036: Assert Reset with 3 entries queued -> RegWrite=0 and Count=0 immediately; no queued write emerges after release.
REQ-037: With WRITEBACK_QUEUE_LOOKUP_EN and Stall=1, push (7,0xA), then (7,0xB) -> LookupRegister=7 gives LookupHit=1, LookupData=0xB; LookupRegister=0 gives LookupHit=0.

Source files
------------

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - write-back FIFO between result producers and the register file write port
// Optional register lookup (forwarding) is enabled by defining WRITEBACK_QUEUE_LOOKUP_EN.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [4:0]               InRegister,
    input  logic [31:0]              InData,
    input  logic                     Stall,
    output logic [4:0]               WriteRegister,
    output logic [31:0]              WriteData,
    output logic                     RegWrite,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
`ifdef WRITEBACK_QUEUE_LOOKUP_EN
    output logic                     Full,
    input  logic [4:0]               LookupRegister,
    output logic                     LookupHit,
    output logic [31:0]              LookupData
`else
    output logic                     Full
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    reg_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic accept;
    logic push;
    logic pop;

    assign Empty   = (count_q == '0);
    assign Full    = (count_q == CW'(DEPTH));
    assign Count   = count_q;
    assign InReady = !Full;

    // Writes to r0 complete the handshake but never occupy a slot.
    assign accept = InValid && InReady;
    assign push   = accept && (InRegister != 5'd0);

    assign RegWrite = !Empty && !Stall;
    assign pop      = RegWrite;

    assign WriteRegister = Empty ? 5'd0  : reg_mem[rd_ptr_q];
    assign WriteData     = Empty ? 32'd0 : data_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone decide what is live.
    always_ff @(posedge Clk) begin
        if (push) begin
            reg_mem[wr_ptr_q]  <= InRegister;
            data_mem[wr_ptr_q] <= InData;
        end
    end

`ifdef WRITEBACK_QUEUE_LOOKUP_EN
    logic [PW-1:0] lookup_idx;

    // Walk oldest to newest so the last match seen is the newest one.
    always_comb begin
        LookupHit  = 1'b0;
        LookupData = 32'd0;
        lookup_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lookup_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (LookupRegister != 5'd0) &&
                (reg_mem[lookup_idx] == LookupRegister)) begin
                LookupHit  = 1'b1;
                LookupData = data_mem[lookup_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - self-checking bench for writeback_queue
// Lookup checks are included when WRITEBACK_QUEUE_LOOKUP_EN is defined.
module tb_writeback_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRegister;
    logic [31:0] InData;
    logic        Stall;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [$clog2(DEPTH):0] Count;
    logic        Empty;
    logic        Full;
`ifdef WRITEBACK_QUEUE_LOOKUP_EN
    logic [4:0]  LookupRegister;
    logic        LookupHit;
    logic [31:0] LookupData;
`endif

    int checks = 0;
    int errors = 0;

    ent_t mq[$];
    ent_t obs[$];

    int   m_sz;
    bit   m_pop;
    bit   m_acc;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .InValid       (InValid),
        .InReady       (InReady),
        .InRegister    (InRegister),
        .InData        (InData),
        .Stall         (Stall),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .Count         (Count),
        .Empty         (Empty),
`ifdef WRITEBACK_QUEUE_LOOKUP_EN
        .Full          (Full),
        .LookupRegister(LookupRegister),
        .LookupHit     (LookupHit),
        .LookupData    (LookupData)
`else
        .Full          (Full)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: a plain queue updated with the handshake rules.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mq.delete();
        end else begin
            m_sz  = mq.size();
            m_pop = (m_sz > 0) && !Stall;
            m_acc = InValid && (m_sz < DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_acc && InRegister != 5'd0) mq.push_back('{InRegister, InData});
        end
    end

    always @(posedge Clk) begin
        if (!Reset && RegWrite) obs.push_back('{WriteRegister, WriteData});
    end

    always @(negedge Clk) begin
        int sz;
        sz = mq.size();
        chk("count",    32'(Count),        32'(sz));
        chk("empty",    32'(Empty),        32'(sz == 0));
        chk("full",     32'(Full),         32'(sz == DEPTH));
        chk("in_ready", 32'(InReady),      32'(sz != DEPTH));
        chk("regwrite", 32'(RegWrite),     32'((sz != 0) && !Stall));
        chk("wreg",     32'(WriteRegister), (sz != 0) ? 32'(mq[0].r) : 32'd0);
        chk("wdata",    WriteData,          (sz != 0) ? mq[0].d : 32'd0);
`ifdef WRITEBACK_QUEUE_LOOKUP_EN
        begin
            bit          hit;
            logic [31:0] ld;
            hit = 1'b0;
            ld  = 32'd0;
            foreach (mq[i]) begin
                if (LookupRegister != 5'd0 && mq[i].r == LookupRegister) begin
                    hit = 1'b1;
                    ld  = mq[i].d;
                end
            end
            chk("lookup_hit",  32'(LookupHit), 32'(hit));
            chk("lookup_data", LookupData,     ld);
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset      = 1'b1;
        InValid    = 1'b0;
        InRegister = 5'd0;
        InData     = 32'd0;
        Stall      = 1'b0;
`ifdef WRITEBACK_QUEUE_LOOKUP_EN
        LookupRegister = 5'd0;
`endif
        repeat (2) tick();
        chk("rst_empty",    32'(Empty),    32'd1);
        chk("rst_full",     32'(Full),     32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_count",    32'(Count),    32'd0);
        chk("rst_wdata",    WriteData,     32'd0);
        Reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(InReady), 32'd1);

        // Single push, one-cycle latency to the write port
        InValid = 1'b1; InRegister = 5'd5; InData = 32'hDEADBEEF;
        tick();
        InValid = 1'b0;
        #1;
        chk("lat_regwrite", 32'(RegWrite),      32'd1);
        chk("lat_wreg",     32'(WriteRegister), 32'd5);
        chk("lat_wdata",    WriteData,          32'hDEADBEEF);
        tick();
        chk("lat_empty_after", 32'(Empty), 32'd1);

        // Fill under stall, refuse extra pushes, then drain in order
        Stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            InValid = 1'b1; InRegister = 5'(k); InData = 32'(8'h11 * k);
            tick();
        end
        InRegister = 5'd9; InData = 32'h99;
        chk("fill_full",  32'(Full),    32'd1);
        chk("fill_ready", 32'(InReady), 32'd0);
        tick();
        chk("fill_refused_count", 32'(Count), 32'd4);
        obs.delete();
        Stall = 1'b0;
        tick();
        InValid = 1'b0;
        chk("pop_no_push_count", 32'(Count), 32'd3);
        repeat (4) tick();
        chk("drain_n", 32'(obs.size()), 32'd4);
        if (obs.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("drain_reg",  32'(obs[k].r), 32'(k + 1));
                chk("drain_data", obs[k].d,      32'(8'h11 * (k + 1)));
            end
        end

        // r0 is accepted but discarded
        obs.delete();
        InValid = 1'b1; InRegister = 5'd0; InData = 32'h12345678;
        #1;
        chk("r0_ready", 32'(InReady), 32'd1);
        tick();
        InValid = 1'b0;
        #1;
        chk("r0_count",    32'(Count),    32'd0);
        chk("r0_regwrite", 32'(RegWrite), 32'd0);
        tick();
        chk("r0_no_write", 32'(obs.size()), 32'd0);

        // Streaming push+pop for 20 cycles; pointers wrap several times
        obs.delete();
        for (int i = 0; i < 20; i++) begin
            InValid = 1'b1; InRegister = 5'((i % 31) + 1); InData = 32'h1000_0000 + 32'(i);
            tick();
            chk("stream_count", 32'(Count), 32'd1);
        end
        InValid = 1'b0;
        repeat (2) tick();
        chk("stream_n", 32'(obs.size()), 32'd20);
        if (obs.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                chk("stream_reg",  32'(obs[i].r), 32'((i % 31) + 1));
                chk("stream_data", obs[i].d,      32'h1000_0000 + 32'(i));
            end
        end

        // Reset with entries queued discards them
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            InValid = 1'b1; InRegister = 5'(20 + k); InData = 32'hA0 + 32'(k);
            tick();
        end
        InValid = 1'b0;
        chk("pre_rst_count", 32'(Count), 32'd3);
        Stall = 1'b0;
        Reset = 1'b1;
        #1;
        chk("mid_rst_regwrite", 32'(RegWrite), 32'd0);
        chk("mid_rst_count",    32'(Count),    32'd0);
        tick();
        Reset = 1'b0;
        obs.delete();
        repeat (4) tick();
        chk("post_rst_no_write", 32'(obs.size()), 32'd0);

`ifdef WRITEBACK_QUEUE_LOOKUP_EN
        // Lookup returns newest match; an entry in flight is not yet visible
        Stall = 1'b1;
        LookupRegister = 5'd7;
        InValid = 1'b1; InRegister = 5'd7; InData = 32'hA;
        #1;
        chk("lk_inflight_hit", 32'(LookupHit), 32'd0);
        tick();
        InData = 32'hB;
        tick();
        InValid = 1'b0;
        #1;
        chk("lk_hit",  32'(LookupHit), 32'd1);
        chk("lk_data", LookupData,     32'hB);
        LookupRegister = 5'd0;
        #1;
        chk("lk_zero_hit", 32'(LookupHit), 32'd0);
        Stall = 1'b0;
        repeat (3) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
